comparator_sort_controller: RTL and testbench



---
 rtl/comparator_sort_controller_pkg.sv | 14 +
 rtl/comparator_sort_controller_if.sv | 30 +++
 rtl/comparator_sort_controller_cmp.sv | 16 +
 rtl/comparator_sort_controller.sv | 141 ++++++++++++++
 tb/tb_comparator_sort_controller.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/comparator_sort_controller_pkg.sv
// Shared types for the comparator sort controller: FSM state encoding and data width.
package comparator_sort_controller_pkg;

  localparam int unsigned DATA_W = 4;

  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/comparator_sort_controller_if.sv
// Producer/consumer valid-ready stream bundle around the sort controller.
interface comparator_sort_controller_if;
  import comparator_sort_controller_pkg::*;

  data_t in_data;
  logic  in_valid;
  logic  in_ready;
  data_t out_data;
  logic  out_valid;
  logic  out_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready
  );

endinterface

// File: rtl/comparator_sort_controller_cmp.sv
// Unsigned 4-bit magnitude comparator shared by every compare step of the sorter.
module four_bit_comparator
  import comparator_sort_controller_pkg::*;
(
  input  data_t x,
  input  data_t y,
  output logic  o_gt,
  output logic  o_eq
);

  always_comb begin
    o_gt = (x > y);
    o_eq = (x == y);
  end

endmodule

// File: rtl/comparator_sort_controller.sv
// Collects DEPTH values, bubble-sorts them through one shared comparator, then streams them out.
module comparator_sort_controller
  import comparator_sort_controller_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  comparator_sort_controller_if.slave   bus,
  output logic                          busy,
  output logic [7:0]                    swap_count
);

  localparam int unsigned      IDX_W     = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] LAST_PASS = IDX_W'(DEPTH - 2);

  state_e           state_q;
  data_t            mem_q [DEPTH];
  logic [IDX_W-1:0] wr_q;
  logic [IDX_W-1:0] rd_q;
  logic [IDX_W-1:0] pass_q;
  logic [IDX_W-1:0] j_q;
  logic             out_valid_q;
  data_t            out_data_q;
  logic             busy_q;
  logic [7:0]       swap_q;

  data_t            cmp_x;
  data_t            cmp_y;
  logic             cmp_gt;
  logic             cmp_eq;
  logic             do_swap;
  logic [IDX_W-1:0] j_nxt;
  logic [IDX_W-1:0] j_last;
  logic [IDX_W-1:0] rd_nxt;

  four_bit_comparator u_cmp (
    .x    (cmp_x),
    .y    (cmp_y),
    .o_gt (cmp_gt),
    .o_eq (cmp_eq)
  );

  always_comb begin
    j_nxt   = j_q + 1'b1;
    rd_nxt  = rd_q + 1'b1;
    j_last  = LAST_PASS - pass_q;
    cmp_x   = '0;
    cmp_y   = '0;
    if (state_q == SORT) begin
      cmp_x = mem_q[j_q];
      cmp_y = mem_q[j_nxt];
    end
    // Equal pairs never swap, which keeps the sort stable.
    do_swap = cmp_gt && !cmp_eq;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q        <= '0;
      rd_q        <= '0;
      pass_q      <= '0;
      j_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      swap_q      <= '0;
    end else begin
      unique case (state_q)
        LOAD: begin
          if (bus.in_valid) begin
            mem_q[wr_q] <= bus.in_data;
            if (wr_q == '0) begin
              swap_q <= '0;
            end
            if (wr_q == LAST_IDX) begin
              state_q <= SORT;
              wr_q    <= '0;
              pass_q  <= '0;
              j_q     <= '0;
              busy_q  <= 1'b1;
            end else begin
              wr_q <= wr_q + 1'b1;
            end
          end
        end

        SORT: begin
          if (do_swap) begin
            mem_q[j_q]   <= cmp_y;
            mem_q[j_nxt] <= cmp_x;
            swap_q       <= swap_q + 8'd1;
          end
          if (j_q == j_last) begin
            j_q <= '0;
            if (pass_q == LAST_PASS) begin
              // Final compare is always at j=0, so the first output is the post-swap low slot.
              state_q     <= DRAIN;
              rd_q        <= '0;
              out_valid_q <= 1'b1;
              out_data_q  <= do_swap ? cmp_y : cmp_x;
            end else begin
              pass_q <= pass_q + 1'b1;
            end
          end else begin
            j_q <= j_nxt;
          end
        end

        DRAIN: begin
          if (bus.out_ready) begin
            if (rd_q == LAST_IDX) begin
              state_q     <= LOAD;
              rd_q        <= '0;
              out_valid_q <= 1'b0;
              out_data_q  <= '0;
              busy_q      <= 1'b0;
            end else begin
              rd_q       <= rd_nxt;
              out_data_q <= mem_q[rd_nxt];
            end
          end
        end

        default: state_q <= LOAD;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == LOAD);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign busy          = busy_q;
  assign swap_count    = swap_q;

endmodule

// File: tb/tb_comparator_sort_controller.sv
// Directed and fuzz stimulus against a sort/inversion-count reference model of the sorter.
module tb_comparator_sort_controller;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic       busy;
  logic [7:0] swap_count;

  comparator_sort_controller_if bus ();

  comparator_sort_controller #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .busy       (busy),
    .swap_count (swap_count)
  );

  int passed = 0;
  int total  = 0;

  logic [3:0] exp_q [$];
  int         rmode = 0;
  logic       held_v = 1'b0;
  logic [3:0] held_d = '0;

  logic [3:0] vec  [DEPTH];
  logic [3:0] lsrt [DEPTH];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endfunction

  // Consumer-side ready pattern: 0 = always ready, 1 = toggle, 2 = random.
  initial bus.out_ready = 1'b1;
  always @(posedge clk) begin
    #1;
    case (rmode)
      1:       bus.out_ready = ~bus.out_ready;
      2:       bus.out_ready = 1'($urandom_range(1));
      default: bus.out_ready = 1'b1;
    endcase
  end

  // Compare process: every valid output beat against the model's sorted queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid) begin
        chk("busy_drain", int'(busy), 1);
        chk("in_ready_drain", int'(bus.in_ready), 0);
        if (held_v) chk("out_hold", int'(bus.out_data), int'(held_d));
        if (bus.out_ready) begin
          held_v = 1'b0;
          if (exp_q.size() == 0) chk("unexpected_out", int'(bus.out_data), -1);
          else chk("out_data", int'(bus.out_data), int'(exp_q.pop_front()));
        end else begin
          held_v = 1'b1;
          held_d = bus.out_data;
        end
      end else begin
        held_v = 1'b0;
      end
    end
  end

  task automatic run_batch(input logic [3:0] v [DEPTH], input logic [3:0] ls [DEPTH],
                           input int mode, input int lit_swaps);
    logic [3:0] srt [$];
    int inv;
    int lat;
    int guard;
    srt = {};
    for (int i = 0; i < DEPTH; i++) srt.push_back(v[i]);
    srt.sort();
    inv = 0;
    for (int i = 0; i < DEPTH; i++)
      for (int k = i + 1; k < DEPTH; k++)
        if (v[i] > v[k]) inv++;
    if (lit_swaps >= 0) begin
      chk("model_swaps", inv, lit_swaps);
      for (int i = 0; i < DEPTH; i++) chk("model_sorted", int'(srt[i]), int'(ls[i]));
    end
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(srt[i]);
    rmode = mode;

    for (int i = 0; i < DEPTH; i++) begin
      bus.in_data  = v[i];
      bus.in_valid = 1'b1;
      @(negedge clk);
      chk("in_ready_load", int'(bus.in_ready), 1);
      @(posedge clk); #1;
    end
    // Junk offered during SORT must be ignored.
    bus.in_data = 4'hF;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      chk("in_ready_sort", int'(bus.in_ready), 0);
      chk("busy_sort", int'(busy), 1);
      @(posedge clk); #1;
      lat++;
    end
    bus.in_valid = 1'b0;
    chk("sort_latency", lat, 6);

    guard = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("drain_done", int'(guard < 200), 1);
    chk("in_ready_after", int'(bus.in_ready), 1);
    chk("busy_after", int'(busy), 0);
    chk("swap_count", int'(swap_count), inv);
    if (lit_swaps >= 0) chk("swap_count_lit", int'(swap_count), lit_swaps);
    exp_q = {};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    #1;
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_data", int'(bus.out_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_swap", int'(swap_count), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    vec = '{4'd3, 4'd1, 4'd2, 4'd0};  lsrt = '{4'd0, 4'd1, 4'd2, 4'd3};
    run_batch(vec, lsrt, 0, 5);
    vec = '{4'd0, 4'd1, 4'd2, 4'd3};  lsrt = '{4'd0, 4'd1, 4'd2, 4'd3};
    run_batch(vec, lsrt, 0, 0);
    vec = '{4'd15, 4'd15, 4'd8, 4'd8}; lsrt = '{4'd8, 4'd8, 4'd15, 4'd15};
    run_batch(vec, lsrt, 0, 4);
    vec = '{4'd9, 4'd4, 4'd7, 4'd2};  lsrt = '{4'd2, 4'd4, 4'd7, 4'd9};
    run_batch(vec, lsrt, 1, 5);
    rmode = 0;

    // Reset in the middle of SORT discards the batch.
    vec = '{4'd5, 4'd3, 4'd6, 4'd1};
    for (int i = 0; i < DEPTH; i++) begin
      bus.in_data  = vec[i];
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", int'(bus.in_ready), 1);
    chk("mid_rst_out_valid", int'(bus.out_valid), 0);
    chk("mid_rst_out_data", int'(bus.out_data), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_swap", int'(swap_count), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    vec = '{4'd2, 4'd2, 4'd1, 4'd0};  lsrt = '{4'd0, 4'd1, 4'd2, 4'd2};
    run_batch(vec, lsrt, 0, 5);

    for (int b = 0; b < 10; b++) begin
      for (int i = 0; i < DEPTH; i++) vec[i] = 4'($urandom_range(15));
      run_batch(vec, lsrt, 2, -1);
    end
    rmode = 0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
